// File: rtl/gphy_pkg.sv
// Shared types and defaults for the GPHY link bring-up controller.
package gphy_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        ALIGN     = 3'd2,
        LINK      = 3'd3
    } gphy_state_e;

    // K28.5 in the low byte, D16.2 in the high byte.
    localparam logic [15:0] DEF_IDLE_WORD = 16'h50BC;
    localparam logic [1:0]  DEF_IDLE_K    = 2'b01;

    // Counter width for a counter that runs over 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gphy_link_ctrl_if.sv
// User TX handshake between the payload source (master) and the link controller (slave).
interface gphy_link_ctrl_if;

    logic [15:0] user_tx_data;
    logic [1:0]  user_tx_datak;
    logic        user_tx_valid;
    logic        user_tx_ready;

    modport master (
        output user_tx_data, user_tx_datak, user_tx_valid,
        input  user_tx_ready
    );

    modport slave (
        input  user_tx_data, user_tx_datak, user_tx_valid,
        output user_tx_ready
    );

endinterface

// File: rtl/gphy_err_window.sv
// Error supervision for LINK: windowed error count with limit detect, plus a saturating total.
module gphy_err_window
    import gphy_pkg::*;
#(
    parameter int ERR_WINDOW = 256,
    parameter int ERR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        err_i,
    output logic        limit_hit_o,
    output logic [15:0] err_cnt_o
);

    localparam int WIN_W = cnt_w(ERR_WINDOW);
    localparam int LIM_W = cnt_w(ERR_LIMIT);

    logic [WIN_W-1:0] win_pos_q;
    logic [LIM_W-1:0] win_err_q;
    logic [15:0]      err_cnt_q;
    logic             err_event;

    assign err_event   = en_i && err_i;
    // An error in the last cycle of a window still closes against that window's count.
    assign limit_hit_o = err_event && (win_err_q == LIM_W'(ERR_LIMIT - 1));
    assign err_cnt_o   = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_pos_q <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (!en_i || win_pos_q == WIN_W'(ERR_WINDOW - 1)) begin
                win_pos_q <= '0;
                win_err_q <= '0;
            end else begin
                win_pos_q <= win_pos_q + 1'b1;
                if (err_event && !limit_hit_o) begin
                    win_err_q <= win_err_q + 1'b1;
                end
            end
            if (err_event && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gphy_link_ctrl.sv
// GPHY link bring-up FSM: PHY reset sequencing, lock wait, comma alignment and LINK supervision.
module gphy_link_ctrl
    import gphy_pkg::*;
#(
    parameter int          RST_CYCLES    = 16,
    parameter int          LOCK_TIMEOUT  = 50000,
    parameter int          ALIGN_TIMEOUT = 50000,
    parameter int          ALIGN_COUNT   = 8,
    parameter int          ERR_WINDOW    = 256,
    parameter int          ERR_LIMIT     = 4,
    parameter logic [15:0] IDLE_WORD     = DEF_IDLE_WORD,
    parameter logic [1:0]  IDLE_K        = DEF_IDLE_K
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    force_retrain,
    input  logic                    pll_locked,
    input  logic                    tx_ready,
    input  logic                    rx_ready,
    input  logic [15:0]             rx_parallel_data,
    input  logic [1:0]              rx_datak,
    input  logic [1:0]              rx_disperr,
    input  logic [1:0]              rx_errdetect,
    gphy_link_ctrl_if.slave         user,
    output logic [15:0]             tx_parallel_data,
    output logic [1:0]              tx_datak,
    output logic                    reset_PHY,
    output logic                    link_up,
    output logic [2:0]              state,
    output logic [7:0]              retrain_cnt,
    output logic [15:0]             err_cnt
);

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int TO_W  = cnt_w((LOCK_TIMEOUT > ALIGN_TIMEOUT) ? LOCK_TIMEOUT : ALIGN_TIMEOUT);
    localparam int AL_W  = cnt_w(ALIGN_COUNT);

    gphy_state_e      state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q;
    logic [TO_W-1:0]  to_q;
    logic [AL_W-1:0]  align_cnt_q;
    logic             reset_phy_q, link_up_q;
    logic [15:0]      tx_data_q;
    logic [1:0]       tx_k_q;
    logic [7:0]       retrain_q;

    logic phy_ok, err_event, good_word, limit_hit, go_reset;

    assign phy_ok    = pll_locked && tx_ready && rx_ready;
    assign err_event = (|rx_disperr) || (|rx_errdetect);
    assign good_word = (rx_parallel_data == IDLE_WORD) && (rx_datak == IDLE_K) && !err_event;

    gphy_err_window #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_err_window (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == LINK),
        .err_i       (err_event),
        .limit_hit_o (limit_hit),
        .err_cnt_o   (err_cnt)
    );

    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (force_retrain) begin
            state_d = RESET;
        end else begin
            unique case (state_q)
                RESET:
                    if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                WAIT_LOCK:
                    if (phy_ok)                                   state_d = ALIGN;
                    else if (to_q == TO_W'(LOCK_TIMEOUT - 1))     state_d = RESET;
                ALIGN:
                    if (!phy_ok)                                  state_d = RESET;
                    else if (good_word && align_cnt_q == AL_W'(ALIGN_COUNT - 1))
                                                                  state_d = LINK;
                    else if (to_q == TO_W'(ALIGN_TIMEOUT - 1))    state_d = RESET;
                LINK:
                    if (!phy_ok || limit_hit)                     state_d = RESET;
                default:
                    state_d = RESET;
            endcase
        end
    end

    // A forced retrain while already in RESET counts as a fresh entry.
    assign go_reset = (state_d == RESET) && (force_retrain || state_q != RESET);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET;
            rst_cnt_q   <= '0;
            to_q        <= '0;
            align_cnt_q <= '0;
            reset_phy_q <= 1'b1;
            link_up_q   <= 1'b0;
            tx_data_q   <= IDLE_WORD;
            tx_k_q      <= IDLE_K;
            retrain_q   <= '0;
        end else begin
            state_q     <= state_d;
            reset_phy_q <= (state_d == RESET);
            link_up_q   <= (state_d == LINK);

            rst_cnt_q   <= (state_d == RESET && !go_reset) ? rst_cnt_q + 1'b1 : '0;
            to_q        <= (state_d == state_q && (state_q == WAIT_LOCK || state_q == ALIGN))
                           ? to_q + 1'b1 : '0;
            align_cnt_q <= (state_q == ALIGN && state_d == ALIGN && good_word)
                           ? align_cnt_q + 1'b1 : '0;

            if (go_reset && retrain_q != 8'hFF) begin
                retrain_q <= retrain_q + 1'b1;
            end

            if (state_d == LINK && link_up_q && user.user_tx_valid) begin
                tx_data_q <= user.user_tx_data;
                tx_k_q    <= user.user_tx_datak;
            end else begin
                tx_data_q <= IDLE_WORD;
                tx_k_q    <= IDLE_K;
            end
        end
    end

    assign user.user_tx_ready = link_up_q;
    assign tx_parallel_data   = tx_data_q;
    assign tx_datak           = tx_k_q;
    assign reset_PHY          = reset_phy_q;
    assign link_up            = link_up_q;
    assign state              = state_q;
    assign retrain_cnt        = retrain_q;

endmodule

// File: tb/tb_gphy_link_ctrl.sv
// Directed bench for gphy_link_ctrl: bring-up, TX scoreboard, error windows, retrains and timeouts.
module tb_gphy_link_ctrl;

    localparam logic [15:0] IDLE_W  = 16'h50BC;
    localparam logic [1:0]  IDLE_KF = 2'b01;
    localparam logic [2:0]  S_RESET = 3'd0;
    localparam logic [2:0]  S_WAIT  = 3'd1;
    localparam logic [2:0]  S_ALIGN = 3'd2;
    localparam logic [2:0]  S_LINK  = 3'd3;

    logic        clk = 1'b0;
    logic        rst, force_retrain, pll_locked, tx_ready, rx_ready;
    logic [15:0] rx_parallel_data;
    logic [1:0]  rx_datak, rx_disperr, rx_errdetect;
    logic [15:0] tx_parallel_data;
    logic [1:0]  tx_datak;
    logic        reset_PHY, link_up;
    logic [2:0]  state;
    logic [7:0]  retrain_cnt;
    logic [15:0] err_cnt;

    gphy_link_ctrl_if uif ();

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] d;
    } tx_t;

    tx_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  pos;
    int  n;

    always #5 clk = ~clk;

    gphy_link_ctrl #(
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .force_retrain    (force_retrain),
        .pll_locked       (pll_locked),
        .tx_ready         (tx_ready),
        .rx_ready         (rx_ready),
        .rx_parallel_data (rx_parallel_data),
        .rx_datak         (rx_datak),
        .rx_disperr       (rx_disperr),
        .rx_errdetect     (rx_errdetect),
        .user             (uif),
        .tx_parallel_data (tx_parallel_data),
        .tx_datak         (tx_datak),
        .reset_PHY        (reset_PHY),
        .link_up          (link_up),
        .state            (state),
        .retrain_cnt      (retrain_cnt),
        .err_cnt          (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, and any queued TX word is compared.
    task automatic step();
        tx_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("tx_word", {14'd0, tx_datak, tx_parallel_data}, {14'd0, e});
        end
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
        int k;
        k = 0;
        while (state !== exp && k < budget) begin
            step();
            k++;
        end
        check(tag, {29'd0, state}, {29'd0, exp});
    endtask

    // Error pulse sampled at LINK window position 'target' (pos counts edges since LINK entry).
    task automatic err_at(input int target, input logic [1:0] dis, input logic [1:0] det);
        while (pos < target) begin
            step();
            pos++;
        end
        rx_disperr   = dis;
        rx_errdetect = det;
        step();
        pos++;
        rx_disperr   = 2'b00;
        rx_errdetect = 2'b00;
    endtask

    task automatic count_reset_high();
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (!reset_PHY) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;           force_retrain = 1'b0;
        pll_locked = 1'b0;    tx_ready = 1'b0;    rx_ready = 1'b0;
        rx_parallel_data = IDLE_W;                rx_datak = IDLE_KF;
        rx_disperr = 2'b00;   rx_errdetect = 2'b00;
        uif.user_tx_data = 16'h0;  uif.user_tx_datak = 2'b00;  uif.user_tx_valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst_state",     {29'd0, state}, {29'd0, S_RESET});
        check("rst_reset_phy", {31'd0, reset_PHY}, 32'd1);
        check("rst_link_up",   {31'd0, link_up}, 32'd0);
        check("rst_tx_ready",  {31'd0, uif.user_tx_ready}, 32'd0);
        check("rst_tx_data",   {16'd0, tx_parallel_data}, {16'd0, IDLE_W});
        check("rst_tx_k",      {30'd0, tx_datak}, {30'd0, IDLE_KF});
        check("rst_retrain",   {24'd0, retrain_cnt}, 32'd0);
        check("rst_err_cnt",   {16'd0, err_cnt}, 32'd0);

        // Clean bring-up
        rst = 1'b0;
        count_reset_high();
        check("reset_phy_len", n, 32'd16);
        check("enter_wait",    {29'd0, state}, {29'd0, S_WAIT});
        repeat (5) step();
        check("wait_hold",     {29'd0, state}, {29'd0, S_WAIT});
        pll_locked = 1'b1;  tx_ready = 1'b1;  rx_ready = 1'b1;
        step();
        check("enter_align",   {29'd0, state}, {29'd0, S_ALIGN});
        repeat (7) step();
        check("align_7_words", {31'd0, link_up}, 32'd0);
        step();
        check("link_8_words",  {31'd0, link_up}, 32'd1);
        check("link_state",    {29'd0, state}, {29'd0, S_LINK});
        check("link_ready",    {31'd0, uif.user_tx_ready}, 32'd1);
        check("link_retrain",  {24'd0, retrain_cnt}, 32'd0);

        // User data path through the scoreboard
        sb.push_back({IDLE_KF, IDLE_W});
        step();
        uif.user_tx_data = 16'h1234;  uif.user_tx_datak = 2'b00;  uif.user_tx_valid = 1'b1;
        sb.push_back({2'b00, 16'h1234});
        step();
        uif.user_tx_valid = 1'b0;
        sb.push_back({IDLE_KF, IDLE_W});
        step();
        uif.user_tx_data = 16'hA5F0;  uif.user_tx_datak = 2'b10;  uif.user_tx_valid = 1'b1;
        sb.push_back({2'b10, 16'hA5F0});
        step();
        uif.user_tx_data = 16'h0F0F;  uif.user_tx_datak = 2'b00;
        sb.push_back({2'b00, 16'h0F0F});
        step();
        uif.user_tx_valid = 1'b0;
        sb.push_back({IDLE_KF, IDLE_W});
        step();

        // Error burst: four errors within 100 cycles of one window
        pos = 0;
        err_at(10, 2'b01, 2'b00);
        err_at(30, 2'b01, 2'b00);
        err_at(60, 2'b01, 2'b00);
        check("burst_3_hold",  {29'd0, state}, {29'd0, S_LINK});
        err_at(90, 2'b01, 2'b00);
        check("burst_4_state", {29'd0, state}, {29'd0, S_RESET});
        check("burst_4_rphy",  {31'd0, reset_PHY}, 32'd1);
        check("burst_4_link",  {31'd0, link_up}, 32'd0);
        check("burst_err_cnt", {16'd0, err_cnt}, 32'd4);
        check("burst_retrain", {24'd0, retrain_cnt}, 32'd1);

        // Three errors in each of two consecutive windows, straddling the wrap
        wait_state(S_LINK, 100, "relink_1");
        pos = 0;
        err_at(250, 2'b01, 2'b00);
        err_at(253, 2'b00, 2'b10);
        err_at(255, 2'b10, 2'b00);
        check("win0_last_hold", {29'd0, state}, {29'd0, S_LINK});
        err_at(256, 2'b00, 2'b01);
        err_at(257, 2'b01, 2'b00);
        err_at(258, 2'b00, 2'b10);
        repeat (3) step();
        check("win1_hold",      {29'd0, state}, {29'd0, S_LINK});
        check("win_err_cnt",    {16'd0, err_cnt}, 32'd10);
        check("win_retrain",    {24'd0, retrain_cnt}, 32'd1);

        // force_retrain mid-LINK while user data is valid
        uif.user_tx_data = 16'hBEEF;  uif.user_tx_datak = 2'b11;  uif.user_tx_valid = 1'b1;
        force_retrain = 1'b1;
        sb.push_back({IDLE_KF, IDLE_W});
        step();
        force_retrain = 1'b0;  uif.user_tx_valid = 1'b0;
        check("force_rphy",     {31'd0, reset_PHY}, 32'd1);
        check("force_link",     {31'd0, link_up}, 32'd0);
        check("force_ready",    {31'd0, uif.user_tx_ready}, 32'd0);
        check("force_state",    {29'd0, state}, {29'd0, S_RESET});
        check("force_retrain",  {24'd0, retrain_cnt}, 32'd2);

        // force_retrain inside RESET restarts the hold count
        repeat (5) step();
        force_retrain = 1'b1;
        step();
        force_retrain = 1'b0;
        count_reset_high();
        check("restart_len",     n, 32'd16);
        check("restart_retrain", {24'd0, retrain_cnt}, 32'd3);

        // Alignment glitch: 7 good, 1 bad K flag, then 8 good
        wait_state(S_ALIGN, 10, "glitch_align");
        repeat (7) step();
        rx_datak = 2'b00;
        step();
        rx_datak = IDLE_KF;
        repeat (7) step();
        check("glitch_hold",    {29'd0, state}, {29'd0, S_ALIGN});
        step();
        check("glitch_link",    {29'd0, state}, {29'd0, S_LINK});
        check("glitch_retrain", {24'd0, retrain_cnt}, 32'd3);

        // Loss of rx_ready in LINK
        rx_ready = 1'b0;
        step();
        check("loss_state",   {29'd0, state}, {29'd0, S_RESET});
        check("loss_retrain", {24'd0, retrain_cnt}, 32'd4);

        // Lock timeout with pll_locked held low
        pll_locked = 1'b0;
        rx_ready   = 1'b1;
        wait_state(S_WAIT, 40, "lock_wait");
        n = 0;
        while (state !== S_RESET && n < 300) begin
            step();
            n++;
        end
        check("lock_to_len",     n, 32'd100);
        check("lock_to_retrain", {24'd0, retrain_cnt}, 32'd5);
        n = 0;
        while (retrain_cnt !== 8'd7 && n < 400) begin
            step();
            n++;
        end
        check("lock_to_3x",      {24'd0, retrain_cnt}, 32'd7);
        check("lock_to_err_cnt", {16'd0, err_cnt}, 32'd10);

        // Only rst clears the counters
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rerst_retrain", {24'd0, retrain_cnt}, 32'd0);
        check("rerst_err_cnt", {16'd0, err_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gphy_link_ctrl.md
Name: gphy_link_ctrl

Overview:
Link bring-up and supervision controller for the 16-bit 8b/10b GPHY transceiver. It sequences the PHY reset, waits for PLL lock and TX/RX ready, and transmits K28.5 idle words until the receiver reports a stable comma stream. It then opens the TX path to user data and supervises disparity and code errors, forcing a retrain when they exceed a threshold. Its status outputs feed the SPI register block, which also drives force_retrain.

Parameters:
RST_CYCLES, 16, number of cycles reset_PHY is held high per reset attempt (min 1)
LOCK_TIMEOUT, 50000, max cycles in WAIT_LOCK before retrying reset
ALIGN_TIMEOUT, 50000, max cycles in ALIGN before retrying reset
ALIGN_COUNT, 8, consecutive good idle words needed to declare link up
ERR_WINDOW, 256, length in cycles of the error-monitoring window
ERR_LIMIT, 4, errors within one window that force a retrain
IDLE_WORD, 16'h50BC, idle pattern (K28.5 in the low byte, D16.2 in the high byte)
IDLE_K, 2'b01, datak value sent with IDLE_WORD

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
force_retrain  in  1  single-cycle request from the SPI register block
pll_locked  in  1  transceiver PLL lock
tx_ready  in  1  transceiver TX ready
rx_ready  in  1  transceiver RX ready
rx_parallel_data  in  16  received word
rx_datak  in  2  received K flags
rx_disperr  in  2  disparity error per byte
rx_errdetect  in  2  code error per byte
user_tx_data  in  16  user payload word
user_tx_datak  in  2  user K flags
user_tx_valid  in  1  user word valid
user_tx_ready  out  1  user word accepted this cycle
tx_parallel_data  out  16  word to the transceiver
tx_datak  out  2  K flags to the transceiver
reset_PHY  out  1  transceiver reset
link_up  out  1  link operational
state  out  3  current FSM state code
retrain_cnt  out  8  reset attempts since rst, saturating
err_cnt  out  16  total errors seen in LINK, saturating

Behaviour:
- All outputs are registered, except user_tx_ready, which equals link_up.
- Reset values:
  - state = RESET (0), with the RESET cycle counter = 0
  - reset_PHY = 1, link_up = 0
  - tx_parallel_data = IDLE_WORD, tx_datak = IDLE_K
  - retrain_cnt = 0, err_cnt = 0
- State codes: RESET = 0, WAIT_LOCK = 1, ALIGN = 2, LINK = 3.
- RESET:
  - reset_PHY = 1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with reset_PHY = 0.
- WAIT_LOCK:
  - Once pll_locked, tx_ready and rx_ready are all 1 in the same cycle, go to ALIGN on the next cycle.
  - After LOCK_TIMEOUT cycles without that condition, go to RESET and increment retrain_cnt.
- ALIGN:
  - Transmit idle.
  - A good word is rx_parallel_data == IDLE_WORD, rx_datak == IDLE_K, and all disperr/errdetect bits 0.
  - Each good word increments an alignment counter; any other word clears it.
  - When the counter reaches ALIGN_COUNT, go to LINK on the next cycle.
  - On ALIGN_TIMEOUT, go to RESET and increment retrain_cnt.
  - Loss of pll_locked, tx_ready or rx_ready, go to RESET and increment retrain_cnt.
- LINK:
  - link_up = 1.
  - When user_tx_valid is 1, transmit the user word and K flags with one cycle of latency; otherwise transmit idle.
  - An error event is a cycle in which any disperr or errdetect bit is 1; it adds 1 to err_cnt (saturating at 16'hFFFF) and to the window error counter.
  - The window counter runs over 0..ERR_WINDOW-1. On wrap, the window error counter clears.
  - An error in the last cycle of a window counts toward the closing window.
  - When the window error count reaches ERR_LIMIT, go to RESET and increment retrain_cnt.
  - Loss of pll_locked, tx_ready or rx_ready, go to RESET and increment retrain_cnt.
- force_retrain:
  - Takes priority in any state: the next state is RESET and retrain_cnt increments.
  - If already in RESET, the RST_CYCLES count restarts.
- On every entry to RESET:
  - link_up drops in the same cycle that reset_PHY rises.
  - TX output reverts to idle immediately.
  - Alignment, window and timeout counters clear.
- retrain_cnt saturates at 8'hFF. Only rst clears retrain_cnt and err_cnt.
- Timeout and cycle counters are sized with $clog2 of their parameter.

Decomposition:
- Package gphy_pkg holds:
  - state encoding constants (RESET, WAIT_LOCK, ALIGN, LINK)
  - IDLE_WORD and IDLE_K defaults
- One sub-module, gphy_err_window, holds the window counter, window error counter and saturating err_cnt. Its outputs are limit_hit and err_cnt.
- The FSM and TX mux stay in the top module.

Test Plan:
- Clean bring-up: raise pll_locked, tx_ready and rx_ready 5 cycles after reset_PHY falls, then loop back idle words. Required: reset_PHY high exactly 16 cycles; state sequence 0→1→2→3; link_up = 1 exactly 8 good words after ALIGN entry; retrain_cnt = 0.
- Lock timeout (LOCK_TIMEOUT = 100): keep pll_locked = 0. Required: return to RESET after 100 cycles and retrain_cnt = 1; after 3 retries, retrain_cnt = 3.
- Alignment glitch: send 7 good words, 1 word with rx_datak = 0, then 8 good words. Required: LINK entered only after the second run; no retrain.
- Error burst (ERR_WINDOW = 256, ERR_LIMIT = 4): in LINK, pulse rx_disperr = 2'b01 four times within 100 cycles. Required: RESET on the fourth error; err_cnt = 4; retrain_cnt = 1. Three errors in each of consecutive windows must not trigger a retrain.
- User data path: in LINK, drive user_tx_data = 16'h1234, user_tx_datak = 0, user_tx_valid = 1 for one cycle. Required: tx_parallel_data = 16'h1234 on the next cycle, then IDLE_WORD with IDLE_K.
- force_retrain mid-LINK while user_tx_valid = 1: Required: the next cycle has reset_PHY = 1, link_up = 0, user_tx_ready = 0, tx = idle, and retrain_cnt increments by 1.
